// File: rtl/ddr_burst_arbiter.sv
// Two-channel DDR burst arbiter: independent round-robin write and read
// directions sharing one downstream burst port each.

module ddr_burst_dir #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ch_req,
    input  logic [15:0] ch_len,
    input  logic [55:0] ch_addr,
    input  logic        burst_finish,
    output logic        busy,
    output logic        grant,
    output logic [1:0]  ch_finish,
    output logic [7:0]  burst_len,
    output logic [27:0] burst_addr,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic [7:0]    len_q, len_d;
    logic [27:0]   addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gap_q, gap_d;
    logic          err_q, err_d;
    logic          pick;

    // Burst state and captured request; last grant resets to 1 so ch0 wins first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            len_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    // Arbitration, burst completion/timeout and the two-cycle request gap
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        len_d     = len_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        err_d     = err_q;
        ch_finish = 2'b00;
        pick      = (ch_req == 2'b11) ? ~last_q : ch_req[1];
        unique case (state_q)
            IDLE: begin
                if (|ch_req) begin
                    grant_d = pick;
                    len_d   = pick ? ch_len[15:8] : ch_len[7:0];
                    addr_d  = pick ? ch_addr[55:28] : ch_addr[27:0];
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (burst_finish || cnt_q == TERM) begin
                    ch_finish = grant_q ? 2'b10 : 2'b01;
                    last_d    = grant_q;
                    gap_d     = 1'b0;
                    state_d   = GAP;
                    if (!burst_finish) begin
                        err_d = 1'b1;
                    end
                end
            end
            GAP: begin
                gap_d = 1'b1;
                if (gap_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q == BUSY);
    assign grant      = grant_q;
    assign burst_len  = len_q;
    assign burst_addr = addr_q;
    assign err        = err_q;

endmodule

module ddr_burst_arbiter #(
    parameter int AXI_DATA_WIDTH = 256,
    parameter int TIMEOUT        = 1024
) (
    input  logic                        m_axi_aclk,
    input  logic                        m_axi_areset,
    input  logic [1:0]                  ch_wr_req,
    input  logic [15:0]                 ch_wr_len,
    input  logic [55:0]                 ch_wr_addr,
    output logic [1:0]                  ch_wr_data_req,
    input  logic [2*AXI_DATA_WIDTH-1:0] ch_wr_data,
    output logic [1:0]                  ch_wr_finish,
    input  logic [1:0]                  ch_rd_req,
    input  logic [15:0]                 ch_rd_len,
    input  logic [55:0]                 ch_rd_addr,
    output logic [1:0]                  ch_rd_data_valid,
    output logic [1:0]                  ch_rd_finish,
    output logic                        wr_burst_req,
    output logic [7:0]                  wr_burst_len,
    output logic [27:0]                 wr_burst_addr,
    input  logic                        wr_burst_data_req,
    output logic [AXI_DATA_WIDTH-1:0]   wr_burst_data,
    input  logic                        wr_burst_finish,
    output logic                        rd_burst_req,
    output logic [7:0]                  rd_burst_len,
    output logic [27:0]                 rd_burst_addr,
    input  logic                        rd_burst_data_valid,
    input  logic                        rd_burst_finish,
    output logic [1:0]                  err
);

    logic wr_busy, wr_gnt, wr_err;
    logic rd_busy, rd_gnt, rd_err;

    ddr_burst_dir #(.TIMEOUT(TIMEOUT)) u_wr (
        .clk          (m_axi_aclk),
        .rst          (m_axi_areset),
        .ch_req       (ch_wr_req),
        .ch_len       (ch_wr_len),
        .ch_addr      (ch_wr_addr),
        .burst_finish (wr_burst_finish),
        .busy         (wr_busy),
        .grant        (wr_gnt),
        .ch_finish    (ch_wr_finish),
        .burst_len    (wr_burst_len),
        .burst_addr   (wr_burst_addr),
        .err          (wr_err)
    );

    ddr_burst_dir #(.TIMEOUT(TIMEOUT)) u_rd (
        .clk          (m_axi_aclk),
        .rst          (m_axi_areset),
        .ch_req       (ch_rd_req),
        .ch_len       (ch_rd_len),
        .ch_addr      (ch_rd_addr),
        .burst_finish (rd_burst_finish),
        .busy         (rd_busy),
        .grant        (rd_gnt),
        .ch_finish    (ch_rd_finish),
        .burst_len    (rd_burst_len),
        .burst_addr   (rd_burst_addr),
        .err          (rd_err)
    );

    assign wr_burst_req = wr_busy;
    assign rd_burst_req = rd_busy;
    assign err          = {rd_err, wr_err};

    // Zero-latency data steering toward the granted channel while busy
    always_comb begin
        ch_wr_data_req   = 2'b00;
        ch_rd_data_valid = 2'b00;
        wr_burst_data    = '0;
        if (wr_busy) begin
            ch_wr_data_req = wr_gnt ? {wr_burst_data_req, 1'b0}
                                    : {1'b0, wr_burst_data_req};
            wr_burst_data  = wr_gnt ? ch_wr_data[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH]
                                    : ch_wr_data[AXI_DATA_WIDTH-1:0];
        end
        if (rd_busy) begin
            ch_rd_data_valid = rd_gnt ? {rd_burst_data_valid, 1'b0}
                                      : {1'b0, rd_burst_data_valid};
        end
    end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Randomized bench for ddr_burst_arbiter against a cycle-level
// behavioural model of both burst directions.

module tb_ddr_burst_arbiter;

    localparam int W  = 64;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     ch_wr_req;
    logic [15:0]    ch_wr_len;
    logic [55:0]    ch_wr_addr;
    logic [1:0]     ch_wr_data_req;
    logic [2*W-1:0] ch_wr_data;
    logic [1:0]     ch_wr_finish;
    logic [1:0]     ch_rd_req;
    logic [15:0]    ch_rd_len;
    logic [55:0]    ch_rd_addr;
    logic [1:0]     ch_rd_data_valid;
    logic [1:0]     ch_rd_finish;
    logic           wr_burst_req;
    logic [7:0]     wr_burst_len;
    logic [27:0]    wr_burst_addr;
    logic           wr_burst_data_req;
    logic [W-1:0]   wr_burst_data;
    logic           wr_burst_finish;
    logic           rd_burst_req;
    logic [7:0]     rd_burst_len;
    logic [27:0]    rd_burst_addr;
    logic           rd_burst_data_valid;
    logic           rd_burst_finish;
    logic [1:0]     err;

    always #5 clk = ~clk;

    ddr_burst_arbiter #(.AXI_DATA_WIDTH(W), .TIMEOUT(TO)) dut (
        .m_axi_aclk          (clk),
        .m_axi_areset        (rst),
        .ch_wr_req           (ch_wr_req),
        .ch_wr_len           (ch_wr_len),
        .ch_wr_addr          (ch_wr_addr),
        .ch_wr_data_req      (ch_wr_data_req),
        .ch_wr_data          (ch_wr_data),
        .ch_wr_finish        (ch_wr_finish),
        .ch_rd_req           (ch_rd_req),
        .ch_rd_len           (ch_rd_len),
        .ch_rd_addr          (ch_rd_addr),
        .ch_rd_data_valid    (ch_rd_data_valid),
        .ch_rd_finish        (ch_rd_finish),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_finish     (rd_burst_finish),
        .err                 (err)
    );

    int errors = 0;
    int checks = 0;

    // model: index 0 = write direction, 1 = read direction
    bit          m_busy[2];
    int          m_gap[2];
    int          m_age[2];
    bit          m_gnt[2];
    bit          m_last[2];
    bit          m_err[2];
    logic [7:0]  m_len[2];
    logic [27:0] m_addr[2];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input bit g);
        return g ? 2'b10 : 2'b01;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0;
            m_gap[d]  = 0;
            m_age[d]  = 0;
            m_gnt[d]  = 0;
            m_last[d] = 1;
            m_err[d]  = 0;
            m_len[d]  = '0;
            m_addr[d] = '0;
        end
    endtask

    function automatic logic [1:0] exp_fin(input int d, input bit fin);
        if (m_busy[d] && (fin || m_age[d] == TO - 1))
            return oh(m_gnt[d]);
        return 2'b00;
    endfunction

    task automatic compare_all();
        logic [W-1:0] xd;
        xd = '0;
        if (m_busy[0])
            xd = m_gnt[0] ? ch_wr_data[2*W-1:W] : ch_wr_data[W-1:0];
        check("wr_req", wr_burst_req, m_busy[0]);
        check("wr_len", wr_burst_len, m_len[0]);
        check("wr_addr", wr_burst_addr, m_addr[0]);
        check("wr_fin", ch_wr_finish, exp_fin(0, wr_burst_finish));
        check("wr_pop", ch_wr_data_req,
              (m_busy[0] && wr_burst_data_req) ? oh(m_gnt[0]) : 2'b00);
        check("wr_data", wr_burst_data, xd);
        check("rd_req", rd_burst_req, m_busy[1]);
        check("rd_len", rd_burst_len, m_len[1]);
        check("rd_addr", rd_burst_addr, m_addr[1]);
        check("rd_fin", ch_rd_finish, exp_fin(1, rd_burst_finish));
        check("rd_vld", ch_rd_data_valid,
              (m_busy[1] && rd_burst_data_valid) ? oh(m_gnt[1]) : 2'b00);
        check("err", err, {m_err[1], m_err[0]});
    endtask

    task automatic step_dir(input int d, input logic [1:0] req,
                            input logic [15:0] len, input logic [55:0] addr,
                            input bit fin);
        bit g;
        if (m_busy[d]) begin
            if (fin || m_age[d] == TO - 1) begin
                if (!fin) m_err[d] = 1;
                m_busy[d] = 0;
                m_gap[d]  = 2;
                m_last[d] = m_gnt[d];
            end else begin
                m_age[d]++;
            end
        end else if (m_gap[d] > 0) begin
            m_gap[d]--;
        end else if (req != 2'b00) begin
            g = (req == 2'b11) ? !m_last[d] : req[1];
            m_gnt[d]  = g;
            m_len[d]  = g ? len[15:8] : len[7:0];
            m_addr[d] = g ? addr[55:28] : addr[27:0];
            m_busy[d] = 1;
            m_age[d]  = 0;
        end
    endtask

    // entered at posedge+1 with inputs set; leaves at next posedge+1
    task automatic tick();
        #2;
        compare_all();
        step_dir(0, ch_wr_req, ch_wr_len, ch_wr_addr, wr_burst_finish);
        step_dir(1, ch_rd_req, ch_rd_len, ch_rd_addr, rd_burst_finish);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] rnd56();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[55:0];
    endfunction

    // mode 0: random finishes, 1: never finish, 2: finish at terminal count
    task automatic run_phase(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            ch_wr_req  = ($urandom % 4 == 0) ? 2'b00 : 2'($urandom);
            ch_rd_req  = ($urandom % 4 == 0) ? 2'b00 : 2'($urandom);
            ch_wr_len  = 16'($urandom);
            ch_rd_len  = 16'($urandom);
            ch_wr_addr = rnd56();
            ch_rd_addr = rnd56();
            ch_wr_data = {$urandom, $urandom, $urandom, $urandom};
            wr_burst_data_req   = 1'($urandom);
            rd_burst_data_valid = 1'($urandom);
            unique case (mode)
                0: begin
                    wr_burst_finish = ($urandom % 6 == 0);
                    rd_burst_finish = ($urandom % 6 == 0);
                end
                1: begin
                    wr_burst_finish = 1'b0;
                    rd_burst_finish = 1'b0;
                end
                default: begin
                    wr_burst_finish = m_busy[0] && m_age[0] == TO - 1;
                    rd_burst_finish = m_busy[1] && m_age[1] == TO - 1;
                end
            endcase
            tick();
        end
    endtask

    logic [27:0] gq[$];
    logic        prev;
    logic [27:0] exp_order [4];
    int          waited;

    initial begin
        ch_wr_req = 0; ch_wr_len = 0; ch_wr_addr = 0; ch_wr_data = 0;
        ch_rd_req = 0; ch_rd_len = 0; ch_rd_addr = 0;
        wr_burst_data_req = 0; wr_burst_finish = 0;
        rd_burst_data_valid = 0; rd_burst_finish = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // single write burst
        ch_wr_req  = 2'b01;
        ch_wr_len  = 16'd16;
        ch_wr_addr = 56'h100;
        tick();
        ch_wr_req = 2'b00;
        wr_burst_finish = 1'b1;
        #1;
        check("s_req", wr_burst_req, 1);
        check("s_len", wr_burst_len, 16);
        check("s_addr", wr_burst_addr, 28'h100);
        check("s_fin", ch_wr_finish, 2'b01);
        tick();
        wr_burst_finish = 1'b0;
        #1;
        check("s_gap1", wr_burst_req, 0);
        tick();
        #1;
        check("s_gap2", wr_burst_req, 0);
        tick();

        // concurrent write ch0 and read ch1
        ch_wr_req = 2'b01;
        ch_rd_req = 2'b10;
        ch_rd_addr = {28'h0ABCDE1, 28'h0};
        tick();
        ch_wr_req = 2'b00;
        ch_rd_req = 2'b00;
        rd_burst_data_valid = 1'b1;
        #1;
        check("c_wr", wr_burst_req, 1);
        check("c_rd", rd_burst_req, 1);
        check("c_vld", ch_rd_data_valid, 2'b10);
        check("c_addr", rd_burst_addr, 28'h0ABCDE1);
        wr_burst_finish = 1'b1;
        rd_burst_finish = 1'b1;
        tick();
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
        rd_burst_data_valid = 1'b0;
        repeat (3) tick();

        run_phase(2, 400);
        check("no_err", err, 2'b00);
        run_phase(0, 800);
        run_phase(1, 400);
        run_phase(0, 300);

        // asynchronous reset mid-burst
        ch_wr_req = 2'b01;
        ch_rd_req = 2'b10;
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
        waited = 0;
        while (!(m_busy[0] && m_busy[1]) && waited < 12) begin
            tick();
            waited++;
        end
        check("r_setup", {m_busy[1], m_busy[0]}, 2'b11);
        check("r_pre", wr_burst_req, 1);
        rst = 1'b1;
        #1;
        check("r_wr", wr_burst_req, 0);
        check("r_rd", rd_burst_req, 0);
        check("r_err", err, 2'b00);
        model_reset();
        ch_wr_req  = 2'b11;
        ch_rd_req  = 2'b00;
        ch_wr_addr = {28'h00000B, 28'h00000A};
        @(posedge clk);
        #1;
        check("r_hold", wr_burst_req, 0);
        rst = 1'b0;

        // contention order with immediate finishes
        prev = 1'b0;
        wr_burst_data_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ch_wr_data = {$urandom, $urandom, $urandom, $urandom};
            wr_burst_finish = m_busy[0];
            #1;
            if (wr_burst_req && !prev) gq.push_back(wr_burst_addr);
            prev = wr_burst_req;
            tick();
        end
        exp_order[0] = 28'hA;
        exp_order[1] = 28'hB;
        exp_order[2] = 28'hA;
        exp_order[3] = 28'hB;
        check("g_cnt", (gq.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size())
                check($sformatf("g_ord%0d", i), gq[i], exp_order[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_burst_arbiter.md
DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

Interface
REQ-001 The block SHALL have the following parameters:
- AXI_DATA_WIDTH, default 256, width of the write burst data.
- TIMEOUT, default 1024, maximum BUSY cycles allowed before a burst is aborted.
REQ-002 The block SHALL have the following ports:
- m_axi_aclk  in  1  single clock.
- m_axi_areset  in  1  asynchronous, active-high reset.
- ch_wr_req  in  2  per-channel write burst request (level).
- ch_wr_len  in  16  2x8 burst lengths; channel n uses [8n+7:8n].
- ch_wr_addr  in  56  2x28 burst addresses; channel n uses [28n+27:28n].
- ch_wr_data_req  out  2  per-channel write data pop strobe.
- ch_wr_data  in  2*AXI_DATA_WIDTH  per-channel write data.
- ch_wr_finish  out  2  per-channel write done pulse.
- ch_rd_req  in  2  per-channel read burst request (level).
- ch_rd_len  in  16  2x8 burst lengths.
- ch_rd_addr  in  56  2x28 burst addresses.
- ch_rd_data_valid  out  2  per-channel read data valid.
- ch_rd_finish  out  2  per-channel read done pulse.
- wr_burst_req  out  1  downstream write request.
- wr_burst_len  out  8  downstream write length.
- wr_burst_addr  out  28  downstream write address.
- wr_burst_data_req  in  1  downstream write data pop.
- wr_burst_data  out  AXI_DATA_WIDTH  downstream write data.
- wr_burst_finish  in  1  downstream write done pulse.
- rd_burst_req  out  1  downstream read request.
- rd_burst_len  out  8  downstream read length.
- rd_burst_addr  out  28  downstream read address.
- rd_burst_data_valid  in  1  downstream read data valid.
- rd_burst_finish  in  1  downstream read done pulse.
- err  out  2  sticky timeout flags; bit0 = write, bit1 = read.
REQ-003 Read data SHALL NOT pass through this block; the downstream rd_burst_data bus is broadcast to all requesters outside the block.

Function
REQ-004 The write and read directions SHALL each have an independent FSM (IDLE, BUSY, GAP) and an independent 1-bit last-grant pointer; the two directions SHALL run concurrently.
REQ-005 In IDLE, arbitration SHALL work as follows:
- If any ch_x_req bit is high, grant round-robin: the channel other than last-grant wins when both request.
- On the grant edge, register grant, len and addr.
- Set x_burst_req=1 and go to BUSY.
- Latency from ch_x_req high to x_burst_req high SHALL be 1 cycle.
REQ-006 In BUSY, x_burst_req, x_burst_len and x_burst_addr SHALL be held stable.
REQ-007 In BUSY, the write data path SHALL be routed as follows:
- ch_wr_data_req[g] = wr_burst_data_req.
- wr_burst_data = ch_wr_data slice g.
- All other pops SHALL be 0.
REQ-008 In BUSY, ch_rd_data_valid[g] SHALL equal rd_burst_data_valid; the other bit SHALL be 0.
REQ-009 The data-path routing in REQ-007/REQ-008 SHALL be combinational, with zero added latency.
REQ-010 When x_burst_finish=1 in BUSY, the block SHALL:
- Pulse ch_x_finish[g] combinationally in the same cycle.
- Drop x_burst_req on the next edge.
- Update last-grant to g.
- Go to GAP.
REQ-011 GAP SHALL hold x_burst_req=0 for exactly 2 cycles, so the downstream edge detector sees a clean rising edge, then return to IDLE.
REQ-012 A BUSY cycle counter SHALL clear on entry to BUSY. If it reaches TIMEOUT-1 without a finish, the block SHALL:
- Set err bit sticky.
- Pulse ch_x_finish[g] for 1 cycle.
- Update last-grant.
- Go to GAP.
REQ-013 If finish and timeout occur in the same cycle, finish SHALL take precedence and err SHALL NOT be set.
REQ-014 Requests SHALL be ignored outside IDLE. A request still high after GAP SHALL be treated as a new burst.
REQ-015 Finish pulses outside BUSY SHALL be ignored, and data strobes outside BUSY SHALL route to no channel.
REQ-016 len=0 and any addr value SHALL be passed through unmodified.

Reset
REQ-017 On m_axi_areset=1, the block SHALL asynchronously:
- Force FSMs to IDLE.
- Clear all outputs, counters and err to 0, including mid-burst.
- Set last-grant to 1, so channel 0 wins the first tie.
REQ-018 After reset release, the first grant SHALL occur no earlier than the first rising edge with reset low.

Verification
REQ-019 Single write: ch_wr_req=01, len=16, addr=0x100 -> one cycle later wr_burst_req=1, len=16, addr=0x100. A wr_burst_finish pulse -> ch_wr_finish=01 in the same cycle, followed by wr_burst_req=0 for 2 cycles.
REQ-020 Contention: ch_wr_req=11 held with immediate finishes -> grant order 0,1,0,1. wr_burst_data equals the granted slice on every wr_burst_data_req.
REQ-021 Concurrency: write on ch0 and read on ch1 issued in the same cycle -> wr_burst_req and rd_burst_req both high one cycle later. ch_rd_data_valid=10 mirrors rd_burst_data_valid.
REQ-022 Timeout: TIMEOUT=64, no finish -> at BUSY cycle 64: err=01, ch_wr_finish pulse, then GAP, then IDLE. err stays 01 until reset.
REQ-023 Collision: finish in the same cycle as the timeout terminal count -> err=00, normal completion.
REQ-024 Reset: m_axi_areset asserted mid-BUSY -> wr_burst_req=0 immediately, without waiting for a clock edge. After release with ch_wr_req=11, channel 0 is granted first.
